// File: rtl/apb2axi_pkg.sv
// Shared definitions for the APB-to-AXI request builder: register offsets, CTRL/STATUS
// bit positions, the packed request descriptor and the push-FSM state type.
package apb2axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned TAG_W      = 4;

  // Register offsets, decoded from paddr[3:2]
  localparam logic [1:0] REG_ADDR    = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_REJ_CLR = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_LEN_LSB   = 0;
  localparam int unsigned CTRL_SIZE_LSB  = 8;
  localparam int unsigned CTRL_WRITE_BIT = 12;
  localparam int unsigned CTRL_GO_BIT    = 31;

  // STATUS bit positions
  localparam int unsigned STAT_PEND_BIT = 0;
  localparam int unsigned STAT_TAG_LSB  = 4;
  localparam int unsigned STAT_REJ_LSB  = 16;

  // Descriptor as seen by the request FIFO, MSB to LSB
  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic                  write;
    logic [2:0]            size;
    logic [7:0]            len;
    logic [AXI_ADDR_W-1:0] addr;
  } req_desc_t;

  localparam int unsigned REQ_W = $bits(req_desc_t);

  typedef enum logic {
    StIdle,
    StPend
  } push_state_e;

endpackage

// File: rtl/apb2axi_req_builder_if.sv
// Bundles the APB3 slave port and the descriptor push port of the request builder.
//   slave  : the request builder side (APB slave, descriptor producer)
//   master : the environment side (APB master, FIFO write port)
interface apb2axi_req_builder_if
  import apb2axi_pkg::*;
#(
  parameter int unsigned APB_ADDR_W = 12
) ();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  req_valid;
  req_desc_t             req_data;
  logic                  req_ready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, req_ready,
    output prdata, pready, pslverr, req_valid, req_data
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, req_ready,
    input  prdata, pready, pslverr, req_valid, req_data
  );

endinterface

// File: rtl/apb2axi_apb_regs.sv
// APB register file of the request builder: address decode, ADDR/CTRL storage, reject
// counter, read mux and the GO accept/reject decision.
// Ports:
//   wr_clk, wr_resetn    clock, asynchronous active-low reset
//   psel_i .. pwdata_i   APB request
//   prdata_o, pslverr_o  APB response, combinational, zero outside the access phase
//   busy_i               a descriptor is pending and is not leaving this cycle
//   pending_i            push FSM is holding a descriptor (STATUS.pending)
//   next_tag_i           tag the next accepted descriptor will carry
//   go_accept_o          GO write accepted this cycle; desc_o is the descriptor to load
module apb2axi_apb_regs
  import apb2axi_pkg::*;
#(
  parameter int unsigned APB_ADDR_W = 12,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  wr_clk,
  input  logic                  wr_resetn,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  input  logic                  busy_i,
  input  logic                  pending_i,
  input  logic [TAG_W-1:0]      next_tag_i,
  output logic                  go_accept_o,
  output req_desc_t             desc_o
);

  localparam logic [2:0] MaxSize = 3'($clog2(DATA_W / 8));

  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [7:0]            rej_q, rej_d;

  logic       access;
  logic       in_range;
  logic [1:0] offset;
  logic [2:0] wsize;
  logic       unused_paddr;

  assign access       = psel_i & penable_i;
  assign in_range     = (paddr_i[APB_ADDR_W-1:4] == '0);
  assign offset       = paddr_i[3:2];
  assign wsize        = pwdata_i[CTRL_SIZE_LSB +: 3];
  assign unused_paddr = ^paddr_i[1:0];

  // Descriptor uses the stored address and the CTRL fields of the current write
  assign desc_o.tag   = next_tag_i;
  assign desc_o.write = pwdata_i[CTRL_WRITE_BIT];
  assign desc_o.size  = wsize;
  assign desc_o.len   = pwdata_i[CTRL_LEN_LSB +: 8];
  assign desc_o.addr  = addr_q;

  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    write_d     = write_q;
    rej_d       = rej_q;
    prdata_o    = '0;
    pslverr_o   = 1'b0;
    go_accept_o = 1'b0;
    if (access) begin
      if (!in_range) begin
        pslverr_o = 1'b1;
      end else begin
        unique case (offset)
          REG_ADDR: begin
            prdata_o[AXI_ADDR_W-1:0] = addr_q;
            if (pwrite_i) addr_d = pwdata_i[AXI_ADDR_W-1:0];
          end
          REG_CTRL: begin
            prdata_o[CTRL_LEN_LSB +: 8]  = len_q;
            prdata_o[CTRL_SIZE_LSB +: 3] = size_q;
            prdata_o[CTRL_WRITE_BIT]     = write_q;
            if (pwrite_i) begin
              len_d   = pwdata_i[CTRL_LEN_LSB +: 8];
              size_d  = wsize;
              write_d = pwdata_i[CTRL_WRITE_BIT];
              if (pwdata_i[CTRL_GO_BIT]) begin
                // Illegal size and busy both reject and both count
                if ((wsize > MaxSize) || busy_i) begin
                  pslverr_o = 1'b1;
                  if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
                end else begin
                  go_accept_o = 1'b1;
                end
              end
            end
          end
          REG_STATUS: begin
            if (pwrite_i) begin
              pslverr_o = 1'b1;
            end else begin
              prdata_o[STAT_PEND_BIT]          = pending_i;
              prdata_o[STAT_TAG_LSB +: TAG_W]  = next_tag_i;
              prdata_o[STAT_REJ_LSB +: 8]      = rej_q;
            end
          end
          REG_REJ_CLR: begin
            if (pwrite_i) rej_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_resetn) begin
    if (!wr_resetn) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rej_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      write_q <= write_d;
      rej_q   <= rej_d;
    end
  end

endmodule

// File: rtl/apb2axi_req_builder.sv
// APB3 front-end that builds tagged AXI request descriptors and pushes them into the
// request FIFO through a valid/ready port. Holds one pending descriptor.
// Ports:
//   wr_clk, wr_resetn  APB/write-domain clock, asynchronous active-low reset
//   bus_io             APB slave signals plus req_valid/req_data/req_ready push port
module apb2axi_req_builder
  import apb2axi_pkg::*;
#(
  parameter int unsigned APB_ADDR_W = 12,
  parameter int unsigned DATA_W     = 32
) (
  input logic                   wr_clk,
  input logic                   wr_resetn,
  apb2axi_req_builder_if.slave  bus_io
);

  push_state_e      state_q, state_d;
  req_desc_t        req_q, req_d;
  req_desc_t        desc;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             go_accept;
  logic             pending;
  logic             busy;

  assign pending = (state_q == StPend);
  // A held descriptor leaving this cycle frees the slot for a back-to-back GO
  assign busy    = pending & ~bus_io.req_ready;

  apb2axi_apb_regs #(
    .APB_ADDR_W (APB_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_regs (
    .wr_clk      (wr_clk),
    .wr_resetn   (wr_resetn),
    .psel_i      (bus_io.psel),
    .penable_i   (bus_io.penable),
    .pwrite_i    (bus_io.pwrite),
    .paddr_i     (bus_io.paddr),
    .pwdata_i    (bus_io.pwdata),
    .prdata_o    (bus_io.prdata),
    .pslverr_o   (bus_io.pslverr),
    .busy_i      (busy),
    .pending_i   (pending),
    .next_tag_i  (tag_q),
    .go_accept_o (go_accept),
    .desc_o      (desc)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tag_d   = tag_q;
    if (go_accept) begin
      req_d = desc;
      tag_d = tag_q + 1'b1;
    end
    unique case (state_q)
      StIdle: if (go_accept) state_d = StPend;
      StPend: if (!go_accept && bus_io.req_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_resetn) begin
    if (!wr_resetn) begin
      state_q <= StIdle;
      req_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
    end
  end

  assign bus_io.pready    = 1'b1;
  assign bus_io.req_valid = pending;
  assign bus_io.req_data  = req_q;

endmodule

// File: tb/tb_apb2axi_req_builder.sv
module tb_apb2axi_req_builder;

  localparam int TB_DATA_W = 32;
  localparam int MAX_SZ    = $clog2(TB_DATA_W / 8);

  logic wr_clk = 1'b0;
  logic wr_resetn;

  always #5 wr_clk = ~wr_clk;

  apb2axi_req_builder_if #(.APB_ADDR_W(12)) bus_if ();

  apb2axi_req_builder #(
    .APB_ADDR_W (12),
    .DATA_W     (TB_DATA_W)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_resetn (wr_resetn),
    .bus_io    (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_addr;
  int          m_len, m_size, m_write, m_tag, m_rej;
  bit          m_pending;
  bit          acc_flag;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_len = 0; m_size = 0; m_write = 0; m_tag = 0; m_rej = 0;
    m_pending = 0; acc_flag = 0;
    exp_q.delete();
  endtask

  // Model of one APB access phase: predicted prdata/pslverr and register side effects
  task automatic model_access(input bit wr, input logic [11:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output bit err);
    int sz;
    logic [63:0] e;
    rd  = '0;
    err = 0;
    if (a[11:4] != 0) begin
      err = 1;
    end else begin
      case (a[3:2])
        2'd0: begin
          rd = m_addr;
          if (wr) m_addr = d;
        end
        2'd1: begin
          rd = 32'(m_len + m_size * 256 + m_write * 4096);
          if (wr) begin
            m_len   = int'(d[7:0]);
            sz      = int'(d[10:8]);
            m_size  = sz;
            m_write = int'(d[12]);
            if (d[31]) begin
              if (sz > MAX_SZ || (m_pending && bus_if.req_ready !== 1'b1)) begin
                err = 1;
                if (m_rej < 255) m_rej++;
              end else begin
                e = (64'(m_tag) << 44) + (64'(m_write) << 43) + (64'(sz) << 40)
                  + (64'(m_len) << 32) + 64'(m_addr);
                exp_q.push_back(e);
                m_tag     = (m_tag + 1) % 16;
                m_pending = 1;
                acc_flag  = 1;
              end
            end
          end
        end
        2'd2: begin
          if (wr) err = 1;
          else rd = 32'(int'(m_pending) + m_tag * 16 + m_rej * 65536);
        end
        default: begin
          if (wr) m_rej = 0;
        end
      endcase
    end
  endtask

  // Advance one clock; a held descriptor leaves when FIFO is ready and no GO replaced it
  task automatic step();
    if (m_pending && bus_if.req_ready === 1'b1 && !acc_flag) m_pending = 0;
    acc_flag = 0;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge wr_clk);
      check("req_valid", 64'(bus_if.req_valid), 64'(m_pending));
      step();
    end
  endtask

  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input string name);
    logic [31:0] erd;
    bit          eerr;
    bus_if.psel    = 1'b1;
    bus_if.penable = 1'b0;
    bus_if.pwrite  = wr;
    bus_if.paddr   = a;
    bus_if.pwdata  = d;
    step();
    bus_if.penable = 1'b1;
    @(negedge wr_clk);
    model_access(wr, a, d, erd, eerr);
    check({name, " pslverr"}, 64'(bus_if.pslverr), 64'(eerr));
    check({name, " pready"}, 64'(bus_if.pready), 64'd1);
    if (!wr) check({name, " prdata"}, 64'(bus_if.prdata), 64'(erd));
    step();
    bus_if.psel    = 1'b0;
    bus_if.penable = 1'b0;
    bus_if.pwrite  = 1'b0;
  endtask

  // Monitor: every FIFO push is compared against the scoreboard; a held descriptor
  // must not change while stalled
  bit          stall_prev = 0;
  logic [63:0] data_prev;
  always @(negedge wr_clk) begin
    if (!wr_resetn) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) check("req_data hold", 64'(bus_if.req_data), data_prev);
      if (bus_if.req_valid === 1'b1 && bus_if.req_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL push: unexpected descriptor 0x%0h, expected none",
                   bus_if.req_data);
        end else begin
          check("push desc", 64'(bus_if.req_data), exp_q.pop_front());
        end
      end
      stall_prev = (bus_if.req_valid === 1'b1) && (bus_if.req_ready !== 1'b1);
      data_prev  = 64'(bus_if.req_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [11:0] A_ADDR = 12'h000;
  localparam logic [11:0] A_CTRL = 12'h004;
  localparam logic [11:0] A_STAT = 12'h008;
  localparam logic [11:0] A_CLR  = 12'h00C;

  initial begin
    logic [31:0] d;
    int          r;
    model_reset();
    wr_resetn        = 1'b0;
    bus_if.psel      = 1'b0;
    bus_if.penable   = 1'b0;
    bus_if.pwrite    = 1'b0;
    bus_if.paddr     = '0;
    bus_if.pwdata    = '0;
    bus_if.req_ready = 1'b0;
    #12;
    check("reset req_valid", 64'(bus_if.req_valid), 64'd0);
    check("reset req_data", 64'(bus_if.req_data), 64'd0);
    check("reset pslverr", 64'(bus_if.pslverr), 64'd0);
    check("reset prdata", 64'(bus_if.prdata), 64'd0);
    @(posedge wr_clk);
    #1;
    wr_resetn = 1'b1;

    // Single request with FIFO ready
    bus_if.req_ready = 1'b1;
    apb(1, A_ADDR, 32'h1000_0040, "wr addr");
    apb(1, A_CTRL, 32'h8000_1203, "go basic");
    idle(2);
    apb(0, A_STAT, 0, "status basic");
    apb(0, A_CTRL, 0, "ctrl readback");
    apb(0, A_ADDR, 0, "addr readback");

    // Busy reject while stalled, then drain
    bus_if.req_ready = 1'b0;
    apb(1, A_CTRL, 32'h8000_0105, "go stall 1");
    apb(1, A_CTRL, 32'h8000_1007, "go stall 2");
    apb(0, A_STAT, 0, "status stalled");
    idle(3);
    bus_if.req_ready = 1'b1;
    idle(2);
    apb(0, A_STAT, 0, "status drained");

    // Back-to-back accepts
    apb(1, A_CTRL, 32'h8000_0011, "b2b 1");
    apb(1, A_CTRL, 32'h8000_1122, "b2b 2");
    idle(2);
    apb(0, A_STAT, 0, "status b2b");

    // Illegal size, busy saturation, clear
    apb(1, A_CLR, 0, "rej clr 0");
    apb(1, A_CTRL, 32'h8000_0300, "go size3");
    idle(1);
    apb(0, A_STAT, 0, "status size3");
    bus_if.req_ready = 1'b0;
    apb(1, A_CTRL, 32'h8000_0001, "go hold");
    for (int i = 0; i < 256; i++) apb(1, A_CTRL, 32'h8000_0002, "go busy");
    apb(0, A_STAT, 0, "status sat");
    apb(1, A_CLR, 0, "rej clr");
    apb(0, A_STAT, 0, "status cleared");
    bus_if.req_ready = 1'b1;
    idle(2);

    // Tag wrap over 17 accepts
    for (int i = 0; i < 17; i++) begin
      apb(1, A_ADDR, 32'h2000_0000 + 32'(i * 64), "wr addr wrap");
      apb(1, A_CTRL, 32'h8000_0200 + 32'(i), "go wrap");
    end
    idle(2);
    apb(0, 12'h010, 0, "unmapped rd");
    apb(1, 12'h010, 32'hFFFF_FFFF, "unmapped wr");
    apb(1, A_STAT, 32'hFFFF_FFFF, "status wr");
    apb(0, A_STAT, 0, "status wrap");

    // Reset while a descriptor is pending and stalled
    bus_if.req_ready = 1'b0;
    apb(1, A_CTRL, 32'h8000_0104, "go pre reset");
    idle(1);
    #2;
    wr_resetn = 1'b0;
    model_reset();
    #1;
    check("async rst req_valid", 64'(bus_if.req_valid), 64'd0);
    check("async rst req_data", 64'(bus_if.req_data), 64'd0);
    @(posedge wr_clk);
    #1;
    wr_resetn = 1'b1;
    apb(0, A_STAT, 0, "status post reset");
    bus_if.req_ready = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: apb(1, A_ADDR, $urandom, "rnd addr");
        1, 2, 3: begin
          d = $urandom & 32'h7FFF_E8FF;
          if ($urandom_range(0, 7) == 0) d[10:8] = 3'($urandom_range(3, 7));
          else d[10:8] = 3'($urandom_range(0, 2));
          d[31] = 1'b1;
          apb(1, A_CTRL, d, "rnd go");
        end
        4: apb(1, A_CTRL, $urandom & 32'h7FFF_FFFF, "rnd ctrl");
        5: apb(0, 12'($urandom_range(0, 3) * 4 + $urandom_range(0, 3)), 0, "rnd rd");
        6: begin
          bus_if.req_ready = ~bus_if.req_ready;
          idle(1);
        end
        7: idle($urandom_range(1, 3));
        8: begin
          if ($urandom_range(0, 1) == 0)
            apb($urandom_range(0, 1) == 1, 12'($urandom_range(16, 4095)), $urandom,
                "rnd unmapped");
          else
            apb(1, A_STAT, $urandom, "rnd status wr");
        end
        default: begin
          if ($urandom_range(0, 2) == 0) apb(1, A_CLR, $urandom, "rnd clr");
          else apb(0, A_STAT, 0, "rnd status");
        end
      endcase
    end
    bus_if.req_ready = 1'b1;
    idle(3);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb2axi_req_builder.md
Name: apb2axi_req_builder

Overview:
APB3 slave front-end in the wr_clk (PCLK) domain. Software programs the address and control registers over APB, then a GO write packs one AXI request descriptor. The block presents the descriptor on a valid/ready push port that drives the write side of the request async FIFO into the AXI domain. It holds one pending descriptor, auto-tags each request, and rejects GO writes it cannot accept with PSLVERR.

Parameters:
APB_ADDR_W, 12, APB address width; only paddr[3:2] decoded, paddr[APB_ADDR_W-1:4] must be 0.
AXI_ADDR_W, 32, AXI address field width (≤32).
DATA_W, 32, AXI data width; max legal size = log2(DATA_W/8).
TAG_W, 4, request tag width.
REQ_W, AXI_ADDR_W+8+3+1+TAG_W (=48), packed descriptor width; equals the FIFO WIDTH.

Ports:
wr_clk  in  1  APB/write-domain clock
wr_resetn  in  1  reset, asynchronous, active-low
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  APB_ADDR_W  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  always 1 (zero wait states)
pslverr  out  1  error response, valid in the access phase
req_valid  out  1  descriptor valid to FIFO wr_valid
req_data  out  REQ_W  {tag, write, size, len, addr}, MSB→LSB
req_ready  in  1  FIFO wr_ready

Behaviour:
- Access = psel & penable. pready tied 1. prdata/pslverr are combinational in the access phase and 0 otherwise.
- Register map:
  - 0x0 ADDR rw [AXI_ADDR_W-1:0]
  - 0x4 CTRL rw: len[7:0], size[10:8], write[12], go[31] write-only (reads 0)
  - 0x8 STATUS ro: pending[0], next_tag[7:4], rej_cnt[23:16]
  - 0xC REJ_CLR wo: any write clears rej_cnt
- Unmapped offset, or a write to STATUS: pslverr=1, no state change, prdata=0.
- CTRL write with go=0 updates len/size/write only.
- CTRL write with go=1: CTRL fields update regardless of outcome. Descriptor is built from the ADDR register and the new pwdata fields.
- Accept condition: !pending OR (req_valid & req_ready) in the same cycle (back-to-back), AND size ≤ log2(DATA_W/8).
  - On accept: next edge loads req_data, sets req_valid=1, tag=next_tag, next_tag increments (wraps 2^TAG_W-1 → 0).
  - On reject: pslverr=1, rej_cnt increments and saturates at 255, no push, tag unchanged.
  - Reject priority: illegal size checked before busy. Both cases count.
- Push FSM, 2 states:
  - IDLE (req_valid=0) → PEND on accept.
  - PEND (req_valid=1, req_data held stable) → IDLE when req_ready=1 with no new accept. Stays PEND when req_ready=1 with a new accept (new descriptor loaded) or when req_ready=0.
- STATUS.pending = (state==PEND).
- Latency: GO access cycle at edge N → req_valid=1 after edge N. Earliest FIFO push at edge N+1.
- Simultaneous REJ_CLR and a reject: impossible (one APB access per cycle).
- Reset (any time, including while PEND):
  - req_valid=0, req_data=0, ADDR=0, CTRL=0, next_tag=0, rej_cnt=0, state=IDLE, prdata=0, pslverr=0.
  - Any pending descriptor is discarded.

Decomposition:
- Package apb2axi_pkg holds:
  - register offsets (REG_ADDR, REG_CTRL, REG_STATUS, REG_REJ_CLR)
  - CTRL bit positions
  - typedef struct packed req_desc_t {tag, write, size, len, addr}, whose $bits equals REQ_W
  - the push-FSM state enum
- Sub-module: apb2axi_apb_regs (APB decode, register storage, prdata/pslverr mux). The push FSM and tag counter stay in the top.

Test Plan:
- Reset, write ADDR=0x1000_0040, CTRL=0x8000_1203 (go, write, size=2, len=3), req_ready=1 → req_valid high one cycle after access; req_data = {tag 0, 1, 3'd2, 8'd3, 0x1000_0040}; pslverr=0; STATUS reads 0x10.
- req_ready=0, two GO writes → first accepted (pending=1); second gets pslverr=1, rej_cnt=1; req_data unchanged. Raise req_ready → handshake, pending=0.
- Back-to-back: req_ready=1, GO on consecutive APB transfers → both accepted; tags 0 and 1 each seen exactly once at the FIFO; no reject.
- GO with size=3 at DATA_W=32 → pslverr=1, no req_valid, rej_cnt=1. 256 busy rejects → rej_cnt saturates at 255. REJ_CLR → 0.
- 17 accepted requests → tag sequence 0..15,0. Read of 0x10 (unmapped) → pslverr=1, prdata=0.
- Assert wr_resetn low while PEND with req_ready=0 → req_valid drops asynchronously. After release, STATUS=0 and no stale descriptor is pushed.
